// File: rtl/id_queue.sv
// Decode-stage front end: DEPTH-entry instruction buffer between IF and EX with
// head decode, load-use bubble insertion, synchronous flush and a registered issue stage.
module id_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_is_load
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   function automatic logic [31:0] imm_decode(input logic [31:0] inst);
      logic [31:0] imm;
      case (inst[6:0])
         OP_LOAD, OP_IMM, OP_JALR:
            imm = {{20{inst[31]}}, inst[31:20]};
         OP_STORE:
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OP_BRANCH:
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {inst[31:12], 12'h000};
         OP_JAL:
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:
            imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

   function automatic logic uses_rs1_f(input logic [6:0] op);
      logic u;
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL: u = 1'b0;
         default:                  u = 1'b1;
      endcase
      return u;
   endfunction

   function automatic logic uses_rs2_f(input logic [6:0] op);
      logic u;
      case (op)
         OP_REG, OP_STORE, OP_BRANCH: u = 1'b1;
         default:                     u = 1'b0;
      endcase
      return u;
   endfunction

   logic [XLEN-1:0] mem_pc_r   [DEPTH];
   logic [XLEN-1:0] mem_inst_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]   count_r, count_next_s;
   logic            in_ready_r;

   logic [XLEN-1:0] head_pc_s, head_inst_s, head_imm_s;
   logic signed [31:0] head_imm32_s;
   logic [6:0]      head_op_s;
   logic [4:0]      head_rs1_s, head_rs2_s, head_rd_s;
   logic            uses_rs1_s, uses_rs2_s, hazard_s;
   logic            has_head_s, load_en_s, push_s, pop_s;

   logic            out_valid_r, out_is_load_r;
   logic [XLEN-1:0] out_pc_r, out_inst_r, out_imm_r;
   logic [4:0]      out_rs1_r, out_rs2_r, out_rd_r;

   // Head-entry decode and load-use hazard detection against the issue register
   always_comb begin
      head_pc_s    = mem_pc_r[rd_ptr_r];
      head_inst_s  = mem_inst_r[rd_ptr_r];
      head_op_s    = head_inst_s[6:0];
      head_rs1_s   = head_inst_s[19:15];
      head_rs2_s   = head_inst_s[24:20];
      head_rd_s    = head_inst_s[11:7];
      head_imm32_s = imm_decode(head_inst_s[31:0]);
      head_imm_s   = XLEN'(head_imm32_s);
      uses_rs1_s   = uses_rs1_f(head_op_s);
      uses_rs2_s   = uses_rs2_f(head_op_s);
      hazard_s     = out_valid_r && out_is_load_r && (out_rd_r != 5'd0) &&
                     ((uses_rs1_s && (head_rs1_s == out_rd_r)) ||
                      (uses_rs2_s && (head_rs2_s == out_rd_r)));
   end

   // Handshake control and next buffer occupancy; flush suppresses both push and pop
   always_comb begin
      has_head_s   = (count_r != CNT_ZERO);
      load_en_s    = !out_valid_r || out_ready;
      push_s       = in_valid && in_ready_r && !flush;
      pop_s        = !flush && load_en_s && has_head_s && !hazard_s;
      count_next_s = count_r;
      if (flush) begin
         count_next_s = CNT_ZERO;
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
         endcase
      end
   end

   // Pointers, occupancy and in_ready (registered view of count < DEPTH)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         in_ready_r <= 1'b1;
      end else if (flush) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         in_ready_r <= 1'b1;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r    <= count_next_s;
         in_ready_r <= (count_next_s < CNT_DEPTH);
      end
   end

   // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_pc_r[wr_ptr_r]   <= in_pc;
         mem_inst_r[wr_ptr_r] <= in_inst;
      end
   end

   // Issue register: capture the head when EX can take it, bubble on hazard or empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r   <= 1'b0;
         out_pc_r      <= {XLEN{1'b0}};
         out_inst_r    <= {XLEN{1'b0}};
         out_rs1_r     <= 5'd0;
         out_rs2_r     <= 5'd0;
         out_rd_r      <= 5'd0;
         out_imm_r     <= {XLEN{1'b0}};
         out_is_load_r <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (load_en_s) begin
         if (pop_s) begin
            out_valid_r   <= 1'b1;
            out_pc_r      <= head_pc_s;
            out_inst_r    <= head_inst_s;
            out_rs1_r     <= head_rs1_s;
            out_rs2_r     <= head_rs2_s;
            out_rd_r      <= head_rd_s;
            out_imm_r     <= head_imm_s;
            out_is_load_r <= (head_op_s == OP_LOAD);
         end else begin
            out_valid_r <= 1'b0;
         end
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_pc      = out_pc_r;
   assign out_inst    = out_inst_r;
   assign out_rs1     = out_rs1_r;
   assign out_rs2     = out_rs2_r;
   assign out_rd      = out_rd_r;
   assign out_imm     = out_imm_r;
   assign out_is_load = out_is_load_r;

endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue: table-driven streaming vectors plus hand-written
// sequences for load-use, immediates, flush and asynchronous reset.
module tb_id_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_is_load;
   logic [31:0] in_pc, in_inst, out_pc, out_inst, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   id_queue #(.XLEN(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
      .out_is_load(out_is_load)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic        exp_ov;
      logic        exp_irdy;
      logic        chk_pc;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                               input logic ordy, input logic exp_ov, input logic exp_irdy,
                               input logic chk_pc, input logic [31:0] exp_pc);
      vec_t v;
      v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
      v.exp_ov = exp_ov; v.exp_irdy = exp_irdy; v.chk_pc = chk_pc; v.exp_pc = exp_pc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_one(input logic [31:0] pc, input logic [31:0] inst);
      in_valid = 1'b1; in_pc = pc; in_inst = inst;
      step();
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      // Stream table: fill 4 entries with EX stalled, then run back-to-back
      vecs.push_back(mk(1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00));
      vecs.push_back(mk(1'b0, 1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00));
      vecs.push_back(mk(1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00));
      vecs.push_back(mk(1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00));
      vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00));
      vecs.push_back(mk(1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00));
      vecs.push_back(mk(1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04));
      for (int k = 0; k < 12; k++)
         vecs.push_back(mk(1'b0, 1'b1, 32'h14 + 32'(4 * k), 1'b1, 1'b1, 1'b1, 1'b1,
                           32'h08 + 32'(4 * k)));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h38));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3C));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00));

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_inst = 32'h0;
      out_ready = 1'b0;
      step(); step();
      chk("reset out_valid", {31'b0, out_valid}, 32'h0);
      chk("reset in_ready", {31'b0, in_ready}, 32'h1);
      chk("reset out_pc", out_pc, 32'h0);
      chk("reset out_imm", out_imm, 32'h0);
      chk("reset out_is_load", {31'b0, out_is_load}, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         flush = vecs[i].fl; in_valid = vecs[i].iv; in_pc = vecs[i].pc; in_inst = NOP;
         out_ready = vecs[i].ordy;
         step();
         chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
         chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_irdy});
         if (vecs[i].chk_pc)
            chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].exp_pc);
      end

      // Load-use: lw x5 then add x6,x5,x2 needs exactly one bubble
      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h0000_A283;
      step();
      in_pc = 32'h104; in_inst = 32'h0022_8333;
      step();
      in_valid = 1'b0;
      chk("lu lw valid", {31'b0, out_valid}, 32'h1);
      chk("lu lw pc", out_pc, 32'h100);
      chk("lu lw rd", {27'b0, out_rd}, 32'd5);
      chk("lu lw is_load", {31'b0, out_is_load}, 32'h1);
      step();
      chk("lu bubble", {31'b0, out_valid}, 32'h0);
      step();
      chk("lu add valid", {31'b0, out_valid}, 32'h1);
      chk("lu add pc", out_pc, 32'h104);
      chk("lu add rs1", {27'b0, out_rs1}, 32'd5);
      chk("lu add rd", {27'b0, out_rd}, 32'd6);
      step();
      chk("lu drained", {31'b0, out_valid}, 32'h0);

      // lw x0 followed by add x6,x0,x2 must not stall
      in_valid = 1'b1; in_pc = 32'h110; in_inst = 32'h0000_A003;
      step();
      in_pc = 32'h114; in_inst = 32'h0020_0333;
      step();
      in_valid = 1'b0;
      chk("x0 lw pc", out_pc, 32'h110);
      step();
      chk("x0 no bubble valid", {31'b0, out_valid}, 32'h1);
      chk("x0 no bubble pc", out_pc, 32'h114);
      step();

      // Immediate formats
      issue_one(32'h120, 32'hFE00_0EE3);
      chk("beq imm", out_imm, 32'hFFFF_FFFC);
      chk("beq inst", out_inst, 32'hFE00_0EE3);
      issue_one(32'h124, 32'h1234_50B7);
      chk("lui imm", out_imm, 32'h1234_5000);
      chk("lui rd", {27'b0, out_rd}, 32'd1);
      issue_one(32'h128, 32'h0020_A423);
      chk("sw imm", out_imm, 32'h0000_0008);
      chk("sw rs2", {27'b0, out_rs2}, 32'd2);
      issue_one(32'h12C, 32'hFFF0_0093);
      chk("addi imm", out_imm, 32'hFFFF_FFFF);
      step();

      // Flush with 3 buffered, out_valid=1, and a simultaneous input
      out_ready = 1'b0; in_inst = NOP; in_valid = 1'b1;
      in_pc = 32'h200; step();
      in_pc = 32'h204; step();
      in_pc = 32'h208; step();
      in_pc = 32'h20C; step();
      chk("pre-flush valid", {31'b0, out_valid}, 32'h1);
      chk("pre-flush pc", out_pc, 32'h200);
      flush = 1'b1; in_pc = 32'h300;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush out_valid", {31'b0, out_valid}, 32'h0);
      chk("flush in_ready", {31'b0, in_ready}, 32'h1);
      out_ready = 1'b1;
      step();
      chk("flush discard 1", {31'b0, out_valid}, 32'h0);
      step();
      chk("flush discard 2", {31'b0, out_valid}, 32'h0);
      issue_one(32'h400, NOP);
      chk("post-flush valid", {31'b0, out_valid}, 32'h1);
      chk("post-flush pc", out_pc, 32'h400);
      step();

      // Asynchronous reset mid-stream with 2 entries buffered
      out_ready = 1'b0; in_valid = 1'b1;
      in_pc = 32'h500; step();
      in_pc = 32'h504; step();
      in_pc = 32'h508; step();
      in_valid = 1'b0;
      chk("pre-reset pc", out_pc, 32'h500);
      #2 rst = 1'b0;
      #1;
      chk("async rst out_valid", {31'b0, out_valid}, 32'h0);
      chk("async rst out_pc", out_pc, 32'h0);
      chk("async rst out_inst", out_inst, 32'h0);
      chk("async rst in_ready", {31'b0, in_ready}, 32'h1);
      #1 rst = 1'b1;
      out_ready = 1'b1;
      issue_one(32'h600, 32'h1234_50B7);
      chk("post-rst valid", {31'b0, out_valid}, 32'h1);
      chk("post-rst pc", out_pc, 32'h600);
      chk("post-rst imm", out_imm, 32'h1234_5000);
      step();
      chk("post-rst lost entries", {31'b0, out_valid}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
